// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
// Holds the FSM state encoding, transaction-type codes and the timeout read pattern.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1
  } state_t;

  localparam logic TT_READ  = 1'b0;
  localparam logic TT_WRITE = 1'b1;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_grant_sel.sv
// Combinational round-robin picker: returns the first pending index after rr_ptr_i,
// wrapping modulo NUM_REQ, so the last granted requester has the lowest priority.
module rr_grant_sel
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] pend_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               any_pending_o
);

  // Scan from farthest to nearest so the nearest pending index is assigned last.
  always_comb begin
    grant_o       = '0;
    any_pending_o = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (pend_i[(int'(rr_ptr_i) + k) % NUM_REQ]) begin
        grant_o       = IDX_W'((int'(rr_ptr_i) + k) % NUM_REQ);
        any_pending_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one pulse-request/pulse-ack RAM port between NUM_REQ requesters, round-robin.
// Optional ack watchdog enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_read_ack,
  output logic [NUM_REQ-1:0]        req_write_ack,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [ADDR_W-1:0]         ram_address,
  output logic [DATA_W-1:0]         ram_out,
  output logic                      ram_read_req,
  output logic                      ram_write_req,
  input  logic [DATA_W-1:0]         ram_in,
  input  logic                      ram_read_ack,
  input  logic                      ram_write_ack,
  output logic                      protocol_err,
  output logic                      timeout_err
);

  localparam int IDX_W = idx_w(NUM_REQ);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                tt_q, tt_d;
  logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
  logic [DATA_W-1:0]   ram_out_q, ram_out_d;
  logic                ram_read_req_q, ram_read_req_d;
  logic                ram_write_req_q, ram_write_req_d;
  logic [NUM_REQ-1:0]  req_read_ack_q, req_read_ack_d;
  logic [NUM_REQ-1:0]  req_write_ack_q, req_write_ack_d;
  logic [DATA_W-1:0]   req_rdata_q, req_rdata_d;
  logic [NUM_REQ-1:0]  pend_rd_q, pend_rd_d;
  logic [NUM_REQ-1:0]  pend_wr_q, pend_wr_d;
  logic                protocol_err_q, protocol_err_d;
  logic [ADDR_W-1:0]   addr_lat_q  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_lat_q [NUM_REQ];

  logic [NUM_REQ-1:0]  accept;
  logic [NUM_REQ-1:0]  proto_hit;
  logic [NUM_REQ-1:0]  clr;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic [IDX_W-1:0]    sel;
  logic                any_pend;
  logic                done;

  rr_grant_sel #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_sel (
    .pend_i        (pend_rd_q | pend_wr_q),
    .rr_ptr_i      (rr_ptr_q),
    .grant_o       (sel),
    .any_pending_o (any_pend)
  );

  assign grant_onehot = NUM_REQ'(1) << grant_q;
  assign clr          = done ? grant_onehot : '0;

  // A requester being cleared this cycle may re-arm in the same cycle.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign accept[gi]    = (req_read[gi] | req_write[gi]) &
                           (~(pend_rd_q[gi] | pend_wr_q[gi]) | clr[gi]);
    assign proto_hit[gi] = req_read[gi] & req_write[gi];
    assign pend_wr_d[gi] = accept[gi] ? req_write[gi] : (pend_wr_q[gi] & ~clr[gi]);
    assign pend_rd_d[gi] = accept[gi] ? (req_read[gi] & ~req_write[gi])
                                      : (pend_rd_q[gi] & ~clr[gi]);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        addr_lat_q[gi]  <= '0;
        wdata_lat_q[gi] <= '0;
      end else if (accept[gi]) begin
        addr_lat_q[gi]  <= req_addr[gi*ADDR_W +: ADDR_W];
        wdata_lat_q[gi] <= req_wdata[gi*DATA_W +: DATA_W];
      end
    end
  end

  assign protocol_err_d = protocol_err_q | (|proto_hit);

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_ptr_d        = rr_ptr_q;
    tt_d            = tt_q;
    ram_address_d   = ram_address_q;
    ram_out_d       = ram_out_q;
    ram_read_req_d  = 1'b0;
    ram_write_req_d = 1'b0;
    req_read_ack_d  = '0;
    req_write_ack_d = '0;
    req_rdata_d     = req_rdata_q;
    done            = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
    wd_cnt_d        = wd_cnt_q;
    timeout_err_d   = timeout_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_pend) begin
          grant_d         = sel;
          rr_ptr_d        = sel;
          tt_d            = pend_wr_q[sel] ? TT_WRITE : TT_READ;
          ram_address_d   = addr_lat_q[sel];
          ram_out_d       = wdata_lat_q[sel];
          ram_read_req_d  = ~pend_wr_q[sel];
          ram_write_req_d = pend_wr_q[sel];
          state_d         = ST_WAIT;
`ifdef RAM_ARB_TIMEOUT_EN
          wd_cnt_d        = '0;
`endif
        end
      end
      ST_WAIT: begin
        if ((tt_q == TT_READ) && ram_read_ack) begin
          done        = 1'b1;
          req_rdata_d = ram_in;
        end else if ((tt_q == TT_WRITE) && ram_write_ack) begin
          done = 1'b1;
`ifdef RAM_ARB_TIMEOUT_EN
        end else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          done          = 1'b1;
          timeout_err_d = 1'b1;
          if (tt_q == TT_READ) req_rdata_d = DATA_W'(TIMEOUT_RDATA);
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
`endif
        end
        if (done) begin
          req_read_ack_d  = (tt_q == TT_READ)  ? grant_onehot : '0;
          req_write_ack_d = (tt_q == TT_WRITE) ? grant_onehot : '0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      grant_q         <= '0;
      rr_ptr_q        <= IDX_W'(NUM_REQ - 1);
      tt_q            <= TT_READ;
      ram_address_q   <= '0;
      ram_out_q       <= '0;
      ram_read_req_q  <= 1'b0;
      ram_write_req_q <= 1'b0;
      req_read_ack_q  <= '0;
      req_write_ack_q <= '0;
      req_rdata_q     <= '0;
      pend_rd_q       <= '0;
      pend_wr_q       <= '0;
      protocol_err_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      rr_ptr_q        <= rr_ptr_d;
      tt_q            <= tt_d;
      ram_address_q   <= ram_address_d;
      ram_out_q       <= ram_out_d;
      ram_read_req_q  <= ram_read_req_d;
      ram_write_req_q <= ram_write_req_d;
      req_read_ack_q  <= req_read_ack_d;
      req_write_ack_q <= req_write_ack_d;
      req_rdata_q     <= req_rdata_d;
      pend_rd_q       <= pend_rd_d;
      pend_wr_q       <= pend_wr_d;
      protocol_err_q  <= protocol_err_d;
    end
  end

`ifdef RAM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign req_read_ack  = req_read_ack_q;
  assign req_write_ack = req_write_ack_q;
  assign req_rdata     = req_rdata_q;
  assign ram_address   = ram_address_q;
  assign ram_out       = ram_out_q;
  assign ram_read_req  = ram_read_req_q;
  assign ram_write_req = ram_write_req_q;
  assign protocol_err  = protocol_err_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed stimulus pushes expectations,
// a monitor pops them as RAM requests and requester acks appear.
module tb_ram_port_arbiter;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_read, req_write;
  logic [N*32-1:0]   req_addr, req_wdata;
  logic [N-1:0]      req_read_ack, req_write_ack;
  logic [31:0]       req_rdata, ram_address, ram_out, ram_in;
  logic              ram_read_req, ram_write_req, ram_read_ack, ram_write_ack;
  logic              protocol_err, timeout_err;

  ram_port_arbiter #(
    .NUM_REQ(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_read_ack(req_read_ack), .req_write_ack(req_write_ack),
    .req_rdata(req_rdata),
    .ram_address(ram_address), .ram_out(ram_out),
    .ram_read_req(ram_read_req), .ram_write_req(ram_write_req),
    .ram_in(ram_in), .ram_read_ack(ram_read_ack), .ram_write_ack(ram_write_ack),
    .protocol_err(protocol_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } ram_exp_t;

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] rdata;
    int          cyc;
  } ack_exp_t;

  ram_exp_t ram_q[$];
  ack_exp_t ack_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  initial begin
    ram_exp_t re;
    ack_exp_t ae;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (ram_read_req || ram_write_req) begin
          if (ram_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ram_req: got rd=%0b wr=%0b addr=%h expected none",
                     ram_read_req, ram_write_req, ram_address);
          end else begin
            re = ram_q.pop_front();
            $display("ram  %s addr=%h data=%h cyc=%0d", ram_write_req ? "wr" : "rd",
                     ram_address, ram_out, cyc);
            check("ram_write_req", 32'(ram_write_req), 32'(re.wr));
            check("ram_read_req", 32'(ram_read_req), 32'(!re.wr));
            check("ram_address", ram_address, re.addr);
            if (re.wr) check("ram_out", ram_out, re.data);
            if (re.cyc >= 0) check("ram_req_cycle", cyc, re.cyc);
          end
        end
        for (int i = 0; i < N; i++) begin
          if (req_read_ack[i] || req_write_ack[i]) begin
            if (ack_q.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_ack: got req%0d rd=%0b wr=%0b expected none",
                       i, req_read_ack[i], req_write_ack[i]);
            end else begin
              ae = ack_q.pop_front();
              $display("ack  req%0d %s rdata=%h cyc=%0d", i, req_write_ack[i] ? "wr" : "rd",
                       req_rdata, cyc);
              check("ack_requester", i, ae.idx);
              check("ack_write", 32'(req_write_ack[i]), 32'(ae.wr));
              check("ack_read", 32'(req_read_ack[i]), 32'(!ae.wr));
              if (!ae.wr) check("req_rdata", req_rdata, ae.rdata);
              if (ae.cyc >= 0) check("ack_cycle", cyc, ae.cyc);
            end
          end
        end
      end
    end
  end

  // RAM model: acks two cycles after the request cycle
  bit          resp_en = 1'b1;
  int          rcnt = 0;
  bit          rwr;
  logic [31:0] raddr;
  logic [31:0] mem [logic [31:0]];

  initial begin
    ram_read_ack  = 1'b0;
    ram_write_ack = 1'b0;
    ram_in        = 32'h0;
    forever begin
      @(negedge clk);
      ram_read_ack  = 1'b0;
      ram_write_ack = 1'b0;
      ram_in        = 32'h5A5A0000 | 32'(cyc);
      if (!resp_en || reset) begin
        rcnt = 0;
      end else begin
        if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) begin
            if (rwr) ram_write_ack = 1'b1;
            else begin
              ram_in       = mem.exists(raddr) ? mem[raddr] : 32'h0;
              ram_read_ack = 1'b1;
            end
          end
        end
        if (ram_read_req || ram_write_req) begin
          rcnt  = 2;
          rwr   = ram_write_req;
          raddr = ram_address;
          if (ram_write_req) mem[ram_address] = ram_out;
        end
      end
    end
  end

  task automatic set_req(input int idx, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] data);
    req_read[idx]          = rd;
    req_write[idx]         = wr;
    req_addr[idx*32 +: 32] = addr;
    req_wdata[idx*32 +: 32] = data;
  endtask

  task automatic end_pulse();
    @(posedge clk); #1;
    req_read  = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic push_ram(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input int c);
    ram_exp_t e;
    e.wr = wr; e.addr = addr; e.data = data; e.cyc = c;
    ram_q.push_back(e);
  endtask

  task automatic push_ack(input int idx, input bit wr, input logic [31:0] rdata, input int c);
    ack_exp_t e;
    e.idx = idx; e.wr = wr; e.rdata = rdata; e.cyc = c;
    ack_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((ram_q.size() != 0 || ack_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (ram_q.size() != 0 || ack_q.size() != 0) begin
      total++; bad++;
      $display("FAIL %s_drain: got %0d ram/%0d ack outstanding expected 0",
               name, ram_q.size(), ack_q.size());
      ram_q.delete();
      ack_q.delete();
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_read_req", 32'(ram_read_req), 32'h0);
    check("rst_ram_write_req", 32'(ram_write_req), 32'h0);
    check("rst_acks", 32'({req_read_ack, req_write_ack}), 32'h0);
    check("rst_req_rdata", req_rdata, 32'h0);
    check("rst_ram_address", ram_address, 32'h0);
    check("rst_ram_out", ram_out, 32'h0);
    check("rst_protocol_err", 32'(protocol_err), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    reset = 1'b0;
  endtask

  task automatic single_read_test();
    int c0;
    @(posedge clk); #1;
    c0 = cyc;
    push_ram(1'b0, 32'h10, 32'h0, c0 + 2);
    push_ack(0, 1'b0, 32'h12345678, c0 + 5);
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    end_pulse();
    drain("single_read");
    check("rdata_hold", req_rdata, 32'h12345678);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    req_read  = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem[32'h10] = 32'h12345678;
    mem[32'h20] = 32'h0BADF00D;
    apply_reset();

    // Test 1: single read with latency check
    single_read_test();

    // Test 2: contention, twice from reset
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      push_ram(1'b0, 32'h10, 32'h0, -1);
      push_ram(1'b0, 32'h20, 32'h0, -1);
      push_ack(0, 1'b0, 32'h12345678, -1);
      push_ack(1, 1'b0, 32'h0BADF00D, -1);
      set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
      set_req(1, 1'b1, 1'b0, 32'h20, 32'h0);
      end_pulse();
      drain("contention");
    end

    // Test 3: write from req 1, then read back from req 0
    push_ram(1'b1, 32'h40, 32'hCAFEF00D, -1);
    push_ack(1, 1'b1, 32'h0, -1);
    set_req(1, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D);
    end_pulse();
    drain("write");
    push_ram(1'b0, 32'h40, 32'h0, -1);
    push_ack(0, 1'b0, 32'hCAFEF00D, -1);
    set_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
    end_pulse();
    drain("readback");

    // Test 4: read+write together from one requester
    check("protocol_err_before", 32'(protocol_err), 32'h0);
    push_ram(1'b1, 32'h50, 32'h11112222, -1);
    push_ack(0, 1'b1, 32'h0, -1);
    set_req(0, 1'b1, 1'b1, 32'h50, 32'h11112222);
    end_pulse();
    drain("protocol");
    check("protocol_err_after", 32'(protocol_err), 32'h1);

    // Test 5: reset while waiting for the RAM ack, then repeat test 1
    resp_en = 1'b0;
    push_ram(1'b0, 32'h10, 32'h0, -1);
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    end_pulse();
    n = 0;
    while (ram_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (ram_q.size() != 0) begin
      total++; bad++;
      $display("FAIL mid_reset_issue: got %0d outstanding expected 0", ram_q.size());
      ram_q.delete();
    end
    repeat (2) @(posedge clk);
    apply_reset();
    resp_en = 1'b1;
    single_read_test();

`ifdef RAM_ARB_TIMEOUT_EN
    // Test 6: RAM never acks, watchdog completes the read
    resp_en = 1'b0;
    check("timeout_err_before", 32'(timeout_err), 32'h0);
    push_ram(1'b0, 32'h60, 32'h0, -1);
    push_ack(0, 1'b0, 32'hDEADBEEF, -1);
    set_req(0, 1'b1, 1'b0, 32'h60, 32'h0);
    end_pulse();
    drain("timeout");
    check("timeout_err_after", 32'(timeout_err), 32'h1);
    resp_en = 1'b1;
`else
    check("timeout_err_tied", 32'(timeout_err), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
